// File: rtl/sisc_exec_unit.sv
// sisc_exec_unit: multi-cycle control FSM and ALU for the SISC core.
module sisc_exec_unit (
  input  logic        clk,
  input  logic        rst_f,
  input  logic [31:0] ir,
  input  logic [31:0] rsa,
  input  logic [31:0] rsb,
  input  logic [3:0]  stat,
  output logic [31:0] alu_result,
  output logic [31:0] wb_data,
  output logic        rf_we,
  output logic [3:0]  stat_out,
  output logic        stat_en,
  output logic [2:0]  state
);
  typedef enum logic [2:0] {
    START0, START1, FETCH, DECODE, EXECUTE, MEM, WRITEBACK, HALT
  } state_t;
  state_t cs, ns;
  logic [31:0] ir_q, a, b, res;
  logic [32:0] sum, diff;
  logic [3:0]  op, fn;
  logic        valid, c, v, wb_sel;
  always_ff @(posedge clk or posedge rst_f)
    if (rst_f) cs <= START0;
    else cs <= ns;
  always_comb begin
    ns = cs;
    case (cs)
      START0:    ns = START1;
      START1:    ns = FETCH;
      FETCH:     ns = DECODE;
      DECODE:    ns = op == 4'hF ? HALT : EXECUTE;
      EXECUTE:   ns = MEM;
      MEM:       ns = WRITEBACK;
      WRITEBACK: ns = FETCH;
      default:   ns = HALT;
    endcase
  end
  always_ff @(posedge clk or posedge rst_f)
    if (rst_f) ir_q <= '0;
    else if (cs == FETCH) ir_q <= ir;
  assign op    = ir_q[31:28];
  assign fn    = ir_q[27:24];
  assign valid = (op == 4'h1 || op == 4'h2) && fn >= 4'h1 && fn <= 4'h8;
  assign a     = rsa;
  assign b     = op == 4'h2 ? {16'h0, ir_q[15:0]} : rsb;
  assign sum   = {1'b0, a} + {1'b0, b};
  assign diff  = {1'b0, a} + {1'b0, ~b} + 33'd1;
  always_comb begin
    res = '0;
    case (fn)
      4'h1:    res = sum[31:0];
      4'h2:    res = diff[31:0];
      4'h3:    res = ~a;
      4'h4:    res = a | b;
      4'h5:    res = a & b;
      4'h6:    res = a ^ b;
      4'h7:    res = a >> b[4:0];
      4'h8:    res = a << b[4:0];
      default: res = '0;
    endcase
  end
  assign c = fn == 4'h1 ? sum[32] : fn == 4'h2 ? diff[32] : 1'b0;
  assign v = fn == 4'h1 ? (a[31] == b[31] && res[31] != a[31]) :
             fn == 4'h2 ? (a[31] != b[31] && res[31] != a[31]) : 1'b0;
  always_ff @(posedge clk or posedge rst_f)
    if (rst_f) alu_result <= '0;
    else if (cs == EXECUTE && valid) alu_result <= res;
  assign stat_en  = cs == EXECUTE && valid;
  assign stat_out = stat_en ? {c, v, res[31], res == 32'h0} : stat;
  assign wb_sel   = cs == WRITEBACK && valid;
  assign wb_data  = wb_sel ? alu_result : 32'h0;
  assign rf_we    = wb_sel;
  assign state    = cs;
endmodule

// File: tb/tb_sisc_exec_unit.sv
// tb_sisc_exec_unit: directed checks of the SISC execute unit.
module tb_sisc_exec_unit;
  logic        clk = 0, rst_f = 1;
  logic [31:0] ir = 0, rsa = 0, rsb = 0;
  logic [3:0]  stat = 4'b0101;
  logic [31:0] alu_result, wb_data;
  logic        rf_we, stat_en;
  logic [3:0]  stat_out;
  logic [2:0]  state;
  int checks = 0, errors = 0;

  sisc_exec_unit dut (
    .clk(clk), .rst_f(rst_f), .ir(ir), .rsa(rsa), .rsb(rsb), .stat(stat),
    .alu_result(alu_result), .wb_data(wb_data), .rf_we(rf_we),
    .stat_out(stat_out), .stat_en(stat_en), .state(state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, got, exp);
    end
  endtask

  // Starts with state == FETCH at a negedge; returns at the next FETCH.
  task automatic run(input string tag, input logic [31:0] i, input logic [31:0] x,
                     input logic [31:0] y, input logic ok, input logic [31:0] res,
                     input logic [3:0] fl, input logic [31:0] prev);
    chk({tag, "_fetch"}, 32'(state), 32'd2);
    ir = i; rsa = x; rsb = y;
    @(negedge clk);
    chk({tag, "_decode"}, 32'(state), 32'd3);
    ir = 32'hF000_0000;
    @(negedge clk);
    chk({tag, "_exec"}, 32'(state), 32'd4);
    chk({tag, "_stat_en"}, 32'(stat_en), 32'(ok));
    chk({tag, "_stat_out"}, 32'(stat_out), 32'(ok ? fl : stat));
    chk({tag, "_res_hold"}, alu_result, prev);
    @(negedge clk);
    chk({tag, "_mem"}, {28'h0, state, stat_en}, {28'h0, 3'd5, 1'b0});
    chk({tag, "_mem_we"}, {31'h0, rf_we}, 32'h0);
    @(negedge clk);
    chk({tag, "_wb_state"}, 32'(state), 32'd6);
    chk({tag, "_wb_we"}, 32'(rf_we), 32'(ok));
    chk({tag, "_alu"}, alu_result, ok ? res : prev);
    chk({tag, "_wb_data"}, wb_data, ok ? res : 32'h0);
    @(negedge clk);
  endtask

  initial begin
    #2;
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_alu", alu_result, 32'h0);
    chk("rst_outs", {29'h0, rf_we, stat_en, 1'b0}, 32'h0);
    chk("rst_wb", wb_data, 32'h0);
    chk("rst_stat_out", 32'(stat_out), 32'h5);
    @(negedge clk); rst_f = 0;
    chk("seq0", {28'h0, state, rf_we}, {28'h0, 3'd0, 1'b0});
    @(negedge clk);
    chk("seq1", {28'h0, state, rf_we}, {28'h0, 3'd1, 1'b0});
    @(negedge clk);
    chk("seq2", {28'h0, state, rf_we}, {28'h0, 3'd2, 1'b0});
    run("add",   32'h1112_0000, 32'd5, 32'd7, 1, 32'd12, 4'b0000, 32'h0);
    run("sub",   32'h1212_0000, 32'd3, 32'd3, 1, 32'd0, 4'b1001, 32'd12);
    run("addov", 32'h1112_0000, 32'h7FFF_FFFF, 32'd1, 1, 32'h8000_0000, 4'b0110, 32'd0);
    run("andi",  32'h2513_00F0, 32'hFFFF_FFFF, 32'h0, 1, 32'h0000_00F0, 4'b0000, 32'h8000_0000);
    run("nopfn", 32'h1912_0000, 32'd9, 32'd9, 0, 32'h0, 4'b0000, 32'h0000_00F0);
    run("nopop", 32'h3112_0000, 32'd9, 32'd9, 0, 32'h0, 4'b0000, 32'h0000_00F0);
    run("nop0",  32'h0112_0000, 32'd9, 32'd9, 0, 32'h0, 4'b0000, 32'h0000_00F0);
    run("srl",   32'h1712_0000, 32'h8000_0000, 32'd4, 1, 32'h0800_0000, 4'b0000, 32'h0000_00F0);
    run("sll",   32'h1812_0000, 32'h4000_0000, 32'd33, 1, 32'h8000_0000, 4'b0010, 32'h0800_0000);
    run("subb",  32'h1212_0000, 32'd1, 32'd2, 1, 32'hFFFF_FFFF, 4'b0010, 32'h8000_0000);
    run("not",   32'h1312_0000, 32'h0F0F_0F0F, 32'd0, 1, 32'hF0F0_F0F0, 4'b0010, 32'hFFFF_FFFF);
    run("xor",   32'h1612_0000, 32'hFF00_FF00, 32'hFF00_FF00, 1, 32'h0, 4'b0001, 32'hF0F0_F0F0);
    run("or",    32'h1412_0000, 32'h0000_0F00, 32'h0000_00F0, 1, 32'h0000_0FF0, 4'b0000, 32'h0);
    ir = 32'h1112_0000; rsa = 32'd1; rsb = 32'd1;
    @(negedge clk); @(negedge clk);
    chk("abort_exec", 32'(state), 32'd4);
    rst_f = 1; #1;
    chk("abort_state", 32'(state), 32'd0);
    chk("abort_outs", {30'h0, rf_we, stat_en}, 32'h0);
    chk("abort_alu", alu_result, 32'h0);
    @(negedge clk); rst_f = 0;
    @(negedge clk); @(negedge clk);
    run("post", 32'h1112_0000, 32'd2, 32'd3, 1, 32'd5, 4'b0000, 32'h0);
    ir = 32'hF000_0000;
    @(negedge clk); @(negedge clk);
    chk("halt", 32'(state), 32'd7);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("halt_hold", {28'h0, state, rf_we}, {28'h0, 3'd7, 1'b0});
    end
    rst_f = 1; #1;
    chk("halt_rst", 32'(state), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/sisc_exec_unit.md
SISC_EXEC_UNIT -- requirements
Module: sisc_exec_unit

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset; clock port clk, reset port rst_f.
REQ-002 The block SHALL have these ports:
- clk  in  1  rising-edge clock
- rst_f  in  1  async active-high reset
- ir  in  32  instruction: opcode ir[31:28], func ir[27:24], rd ir[23:20], rs ir[19:16], rt ir[15:12], imm ir[15:0]
- rsa  in  32  register file read port A (rs)
- rsb  in  32  register file read port B (rt)
- stat  in  4  current status register {C,V,N,Z}
- alu_result  out  32  registered ALU result
- wb_data  out  32  register-file write data
- rf_we  out  1  register-file write enable
- stat_out  out  4  new status flags {C,V,N,Z}
- stat_en  out  1  status register load enable
- state  out  3  current control state

Function
REQ-003 Control FSM SHALL use states START0=0, START1=1, FETCH=2, DECODE=3, EXECUTE=4, MEM=5, WRITEBACK=6, HALT=7.
REQ-004 Transitions SHALL be START0->START1->FETCH->DECODE->EXECUTE->MEM->WRITEBACK->FETCH, one per clock.
REQ-005 In DECODE, opcode 1111 SHALL transition to HALT; HALT SHALL be held until reset.
REQ-006 ir SHALL be captured into an internal instruction register on the clock edge leaving FETCH; all decoding SHALL use the captured value.
REQ-007 Opcode 0000 SHALL be NOP: no register write, no status update.
REQ-008 Opcode 0001 SHALL be register ALU op: A=rsa, B=rsb.
REQ-009 Opcode 0010 SHALL be immediate ALU op: A=rsa, B=zero-extended imm.
REQ-010 Opcodes 0011-1110 SHALL be treated as NOP.
REQ-011 Func encoding SHALL be:
- 0001 ADD A+B
- 0010 SUB A-B
- 0011 NOT ~A
- 0100 OR
- 0101 AND
- 0110 XOR
- 0111 SRL A>>B[4:0]
- 1000 SLL A<<B[4:0]
REQ-012 Any other func SHALL be treated as NOP.
REQ-013 alu_result SHALL be registered on the clock edge leaving EXECUTE for valid ALU ops.
REQ-014 alu_result SHALL hold its value in all other states.
REQ-015 Arithmetic SHALL be 32-bit modulo 2^32.
REQ-016 Z SHALL be 1 iff result==0.
REQ-017 N SHALL equal result[31].
REQ-018 ADD: C = carry out of bit 31; V = operand signs equal and result sign differs.
REQ-019 SUB: computed as A+~B+1; C = carry out; V = operand signs differ and result sign differs from A.
REQ-020 Logic and shift ops: C=0, V=0.
REQ-021 stat_out SHALL carry the new flags during EXECUTE.
REQ-022 stat_en SHALL pulse high for exactly the EXECUTE cycle of valid ALU ops.
REQ-023 The stat input SHALL be unused except as a pass-through: stat_out=stat when stat_en=0.
REQ-024 wb_data SHALL be a 2:1 mux: alu_result when the write-back select is 1, 32'h0 when 0.
REQ-025 The write-back select SHALL be 1 only in WRITEBACK for valid ALU ops.
REQ-026 rf_we SHALL be 1 only in WRITEBACK for valid ALU ops, for exactly one cycle.
REQ-027 MEM SHALL be a pass-through cycle with no outputs asserted.

Reset
REQ-028 Reset SHALL force state=START0, alu_result=0, rf_we=0, stat_en=0, wb_data=0, and clear the internal instruction register, asynchronously.
REQ-029 stat_out SHALL equal stat during reset.
REQ-030 Reset asserted mid-instruction SHALL abort it with no write and no status update.
REQ-031 After release of reset, FETCH SHALL be reached on the second clock.

Verification
REQ-032 Reset, release, run 3 clocks -> state sequence 0,1,2; rf_we=0 throughout.
REQ-033 ir=32'h1112_0000 (ADD), rsa=5, rsb=7 -> EXECUTE: stat_en=1, stat_out=0000; WRITEBACK: alu_result=12, wb_data=12, rf_we=1.
REQ-034 SUB with rsa=3, rsb=3 -> alu_result=0, Z=1, C=1, N=0, V=0.
REQ-035 ADD with rsa=32'h7FFF_FFFF, rsb=1 -> result 32'h8000_0000, N=1, V=1, C=0.
REQ-036 ir=32'h2513_00F0 (immediate AND), rsa=32'hFFFF_FFFF -> result 32'h0000_00F0.
REQ-037 ir=32'hF000_0000 -> HALT (7) after DECODE, held with rf_we=0; assert rst_f -> state=0 immediately.
